acumulador_mac: RTL and testbench

Multiply-accumulate stage directly upstream of the accumulator output mux. It computes the signed dot product of TAPS sample/coefficient pairs into a 2N-bit register. It drives the mux's accumulator input (Acum) and its 2-bit select. The mux passes the result only once a full accumulation has completed, and outputs zero otherwise.

---
 rtl/acum_pkg.sv | 14 +
 rtl/acumulador_mac_if.sv | 23 ++
 rtl/sumador_sat.sv | 29 ++
 rtl/acumulador_mac.sv | 76 +++++++
 tb/tb_acumulador_mac.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/acum_pkg.sv
// Shared types and constants for the MAC accumulator and the downstream output mux.
package acum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mux select codes; the output mux decodes these same values.
  localparam logic [1:0] SEL_ACUM = 2'b00;
  localparam logic [1:0] SEL_CERO = 2'b01;

endpackage

// File: rtl/acumulador_mac_if.sv
// Handshake and data bundle between a sample/coefficient source and acumulador_mac.
interface acumulador_mac_if #(
  parameter int N = 25
);
  logic                  start;
  logic                  valid_in;
  logic signed [N-1:0]   x_in;
  logic signed [N-1:0]   coef_in;
  logic signed [2*N-1:0] acum;
  logic [1:0]            select;
  logic                  busy;
  logic                  done;

  modport master (
    output start, valid_in, x_in, coef_in,
    input  acum, select, busy, done
  );

  modport slave (
    input  start, valid_in, x_in, coef_in,
    output acum, select, busy, done
  );
endinterface

// File: rtl/sumador_sat.sv
// W-bit signed adder; wraps modulo 2^W, or clamps to the signed range when ACUM_SAT_EN is defined.
module sumador_sat #(
  parameter int W = 50
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

`ifdef ACUM_SAT_EN
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] suma;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    suma = {a[W-1], a} + {b[W-1], b};
    y    = suma[W-1:0];
    // The two top bits disagree only when the true sum left the W-bit range.
    if (suma[W] != suma[W-1]) begin
      y = suma[W] ? MIN_VAL : MAX_VAL;
    end
  end
`else
  assign y = a + b;
`endif

endmodule

// File: rtl/acumulador_mac.sv
// Signed dot product of TAPS sample/coefficient pairs; drives the output mux Acum input and select.
// Build option: define ACUM_SAT_EN for a saturating accumulator instead of wrap-around.
module acumulador_mac
  import acum_pkg::*;
#(
  parameter int N    = 25,
  parameter int TAPS = 5,
  parameter int CW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  acumulador_mac_if.slave  bus
);

  state_t                state, state_nx;
  logic [CW-1:0]         count;
  logic                  result_valid;
  logic signed [2*N-1:0] acum_q;
  logic signed [2*N-1:0] prod;
  logic signed [2*N-1:0] suma;
  logic                  accept;
  logic                  last;

  assign accept = (state == ACC) && bus.valid_in;
  assign last   = accept && (count == CW'(TAPS - 1));

  // Operands are widened first so the product keeps all 2N bits.
  assign prod = (2*N)'(bus.x_in) * (2*N)'(bus.coef_in);

  sumador_sat #(.W(2*N)) u_sumador (
    .a (acum_q),
    .b (prod),
    .y (suma)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ACC;
      ACC:     if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acum_q       <= '0;
      count        <= '0;
      result_valid <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        acum_q       <= '0;
        count        <= '0;
        result_valid <= 1'b0;
      end else if (accept) begin
        acum_q <= suma;
        count  <= count + 1'b1;
        // Raised together with the final sum so select flips in the DONE cycle itself.
        if (last) result_valid <= 1'b1;
      end
    end
  end

  assign bus.acum   = acum_q;
  assign bus.select = result_valid ? SEL_ACUM : SEL_CERO;
  assign bus.busy   = (state == ACC);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_acumulador_mac.sv
// Directed self-checking bench for acumulador_mac (TAPS=4); results are checked from a scoreboard queue at each done.
module tb_acumulador_mac;
  import acum_pkg::*;

  localparam int N    = 25;
  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic reset;

  acumulador_mac_if #(.N(N)) m ();

  acumulador_mac #(.N(N), .TAPS(TAPS), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  int     done_cnt    = 0;
  int     cyc         = 0;
  longint model       = 0;
  longint sb[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference accumulate on a 2N-bit signed register.
  function automatic longint model_add(input longint acc, input longint x, input longint c);
    longint s;
    longint maxv;
    longint minv;
    maxv = (longint'(1) <<< (2*N-1)) - 1;
    minv = -(longint'(1) <<< (2*N-1));
    s = acc + x * c;
`ifdef ACUM_SAT_EN
    if (s > maxv) s = maxv;
    if (s < minv) s = minv;
`else
    s = (s <<< (64 - 2*N)) >>> (64 - 2*N);
`endif
    return s;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge, and any done pulse is scored.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (m.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        check("done_acum", longint'(m.acum), sb.pop_front());
        check("done_select", longint'(m.select), longint'(SEL_ACUM));
      end
    end
  endtask

  task automatic do_start();
    m.start = 1'b1;
    step();
    m.start = 1'b0;
    model = 0;
  endtask

  task automatic feed(input int x, input int c, input int gap, input bit last_one);
    m.x_in     = N'(x);
    m.coef_in  = N'(c);
    m.valid_in = 1'b1;
    model = model_add(model, longint'(x), longint'(c));
    if (last_one) sb.push_back(model);
    step();
    m.valid_in = 1'b0;
    m.x_in     = N'(12345);
    m.coef_in  = N'(-777);
    for (int g = 0; g < gap; g++) begin
      step();
      check("gap_busy", longint'(m.busy), 1);
    end
  endtask

  int start_cyc;
  int done_before;

  initial begin
    reset      = 1'b1;
    m.start    = 1'b0;
    m.valid_in = 1'b0;
    m.x_in     = '0;
    m.coef_in  = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_acum",   longint'(m.acum),   0);
    check("rst_select", longint'(m.select), longint'(SEL_CERO));
    check("rst_busy",   longint'(m.busy),   0);
    check("rst_done",   longint'(m.done),   0);

    // 1: four consecutive 2x3 products -> 24, done four edges after the start edge
    do_start();
    start_cyc = cyc;
    check("t1_busy",   longint'(m.busy),   1);
    check("t1_select", longint'(m.select), longint'(SEL_CERO));
    done_before = done_cnt;
    for (int i = 0; i < TAPS; i++) feed(2, 3, 0, i == TAPS - 1);
    check("t1_done_latency", longint'(cyc - start_cyc), 4);
    check("t1_done_seen", longint'(done_cnt - done_before), 1);
    step();
    check("t1_done_once", longint'(m.done), 0);
    check("t1_select_hold", longint'(m.select), longint'(SEL_ACUM));
    check("t1_acum_hold", longint'(m.acum), 24);

    // 2: -5x7 with idle gaps of 1..3 cycles -> -140
    do_start();
    feed(-5, 7, 1, 0);
    feed(-5, 7, 2, 0);
    feed(-5, 7, 3, 0);
    check("t2_no_early_done", longint'(done_cnt), 1);
    feed(-5, 7, 0, 1);
    step();

    // 3: reset (together with start) after two products, then a clean 4x(1x1) run
    do_start();
    feed(3, 3, 0, 0);
    feed(3, 3, 0, 0);
    reset   = 1'b1;
    m.start = 1'b1;
    step();
    reset   = 1'b0;
    m.start = 1'b0;
    check("t3_rst_acum",   longint'(m.acum),   0);
    check("t3_rst_select", longint'(m.select), longint'(SEL_CERO));
    check("t3_rst_busy",   longint'(m.busy),   0);
    step();
    check("t3_idle_busy",  longint'(m.busy),   0);
    do_start();
    for (int i = 0; i < TAPS; i++) feed(1, 1, 0, i == TAPS - 1);
    step();

    // 4: start pulsed mid-accumulation is ignored -> 400
    do_start();
    feed(10, 10, 0, 0);
    m.start = 1'b1;
    step();
    m.start = 1'b0;
    check("t4_busy", longint'(m.busy), 1);
    for (int i = 1; i < TAPS; i++) feed(10, 10, 0, i == TAPS - 1);

    // 5: (-2^24)^2 four times; sum 2^50 wraps to 0 or clamps to 2^49-1
    step();
    do_start();
    for (int i = 0; i < TAPS; i++) feed(-(1 << 24), -(1 << 24), 0, i == TAPS - 1);
`ifdef ACUM_SAT_EN
    check("t5_expected", sb.size() == 0 ? longint'(m.acum) : 0, (longint'(1) <<< 49) - 1);
`else
    check("t5_expected", sb.size() == 0 ? longint'(m.acum) : 1, 0);
`endif

    // 6: start held through DONE (ignored) and accepted in the next IDLE cycle
    m.start = 1'b1;
    step();
    check("t6_done_start_ignored", longint'(m.busy), 0);
    step();
    m.start = 1'b0;
    model = 0;
    check("t6_b2b_busy",   longint'(m.busy),   1);
    check("t6_run_select", longint'(m.select), longint'(SEL_CERO));
    for (int i = 0; i < TAPS; i++) begin
      if (i > 0) check("t6_run_select_mid", longint'(m.select), longint'(SEL_CERO));
      feed(1, -1, 0, i == TAPS - 1);
    end
    step();
    check("t6_select_after", longint'(m.select), longint'(SEL_ACUM));
    check("t6_acum_after",   longint'(m.acum),   -4);

    check("sb_empty",   longint'(sb.size()), 0);
    check("done_count", longint'(done_cnt),  6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
